// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Purpose:
//   Captures NUM_DIGITS hex nibbles into a shadow register and time-multiplexes
//   them onto one shared, active-low seven-segment bus. Each digit is held for
//   REFRESH_DIV cycles: one blank cycle (anti-ghosting) followed by
//   REFRESH_DIV-1 lit cycles. A one-cycle frame_done strobe marks the scan
//   wrapping from the last digit back to digit 0.
//
// Parameters:
//   NUM_DIGITS   number of digits scanned (2..8)
//   REFRESH_DIV  clock cycles each digit slot lasts (>= 2)
//
// Ports:
//   clock       system clock, all state updates on the rising edge
//   clear       synchronous active-high reset, wins over load
//   load        capture strobe, shadow <= nibbles while high
//   nibbles     packed digit values, digit k = nibbles[4k+3:4k]
//   seg         segment drive, active-low, seg[0]=a .. seg[6]=g
//   anode       digit enables, active-low, one-hot-low or all ones
//   frame_done  one-cycle pulse when the scan wraps to digit 0
//
// Build options:
//   SEG_SCAN_LEADING_ZERO_BLANK_EN  when defined, digit k (k >= 1) is blanked
//   whenever shadow digits k..NUM_DIGITS-1 are all zero. Digit 0 always shows.
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] nibbles,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_OFF   = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = '1;

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;

  logic                  tick;
  logic                  last_digit;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] lz_mask;

  // Active-low hex font, bit 0 is segment a.
  function automatic logic [6:0] hex_decode(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'b1000000;
      4'h1:    pattern = 7'b1111001;
      4'h2:    pattern = 7'b0100100;
      4'h3:    pattern = 7'b0110000;
      4'h4:    pattern = 7'b0011001;
      4'h5:    pattern = 7'b0010010;
      4'h6:    pattern = 7'b0000010;
      4'h7:    pattern = 7'b1111000;
      4'h8:    pattern = 7'b0000000;
      4'h9:    pattern = 7'b0010000;
      4'hA:    pattern = 7'b0001000;
      4'hB:    pattern = 7'b0000011;
      4'hC:    pattern = 7'b1000110;
      4'hD:    pattern = 7'b0100001;
      4'hE:    pattern = 7'b0000110;
      4'hF:    pattern = 7'b0001110;
      default: pattern = SEG_OFF;
    endcase
    return pattern;
  endfunction

  assign tick       = (cnt == CNT_LAST);
  assign last_digit = (idx == IDX_LAST);

  // Shadow capture. The display only ever reads the shadow, so the upstream
  // register bank can change freely between loads.
  always_ff @(posedge clock) begin
    if (clear) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= nibbles;
    end
  end

  // Refresh counter and digit index. The index advances on the last cycle of
  // a slot so that the following cycle (cnt == 0) is the blank guard cycle
  // that separates the old anode from the new one.
  always_ff @(posedge clock) begin
    if (clear) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (tick) begin
        cnt <= '0;
        if (last_digit) begin
          idx <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  // lz_mask[k] is set when digit k and every digit above it are zero. The
  // running flag walks down from the most significant digit; digit 0 is
  // never masked so a value of zero still shows a single "0".
  always_comb begin
    logic run_zero;
    lz_mask  = '0;
    run_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run_zero   = run_zero & (shadow[4*k +: 4] == 4'h0);
      lz_mask[k] = run_zero;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Select the nibble and leading-zero flag for the current index. Written as
  // a compare loop so idx values outside 0..NUM_DIGITS-1 (never reached) fall
  // back to a blank digit rather than reading past the shadow register.
  always_comb begin
    cur_digit = 4'h0;
    cur_blank = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_digit = shadow[4*k +: 4];
        cur_blank = lz_mask[k];
      end
    end
  end

  // Registered outputs, loaded from the pre-edge counter, index and shadow.
  // cnt == 0 is the guard cycle: all anodes off so the segment bus can change
  // without the previous digit's pattern ghosting onto the new digit.
  always_ff @(posedge clock) begin
    if (clear) begin
      seg        <= SEG_OFF;
      anode      <= ANODE_OFF;
      frame_done <= 1'b0;
    end else begin
      if (cnt == '0 || cur_blank) begin
        seg   <= SEG_OFF;
        anode <= ANODE_OFF;
      end else begin
        seg   <= hex_decode(cur_digit);
        anode <= ~(NUM_DIGITS'(1) << idx);
      end
      frame_done <= tick & last_digit;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Directed, table-driven bench for seg_scan_driver with NUM_DIGITS=4 and
// REFRESH_DIV=4. A queue of per-cycle vectors holds the inputs applied before
// an edge and the seg/anode/frame_done values expected after it. A free-run
// sequence afterwards checks frame_done spacing. A background monitor checks
// that no more than one anode is ever low.
// Build option SEG_SCAN_LEADING_ZERO_BLANK_EN switches the expected values for
// leading-zero blanking.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic        clr;
    logic        ld;
    logic [15:0] nib;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        fd;
  } vec_t;

  logic        clock;
  logic        clear;
  logic        load;
  logic [15:0] nibbles;
  logic [6:0]  seg;
  logic [3:0]  anode;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  bit running = 1'b0;

  vec_t vecs[$];

  seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .load       (load),
    .nibbles    (nibbles),
    .seg        (seg),
    .anode      (anode),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // At most one anode may be low in any cycle, including across digit changes.
  always @(negedge clock) begin
    if (running) begin
      checks++;
      if ($countones(~anode) > 1) begin
        errors++;
        $display("[TB] FAIL anode_onehot: anode=%b has more than one low bit", anode);
      end
    end
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected anode/seg for a lit cycle of digit k given the shadow contents.
  task automatic expLit(input logic [15:0] sh, input int k,
                        output logic [3:0] an, output logic [6:0] sg);
    logic [3:0] d;
    d  = sh[4*k +: 4];
    an = ~(4'b0001 << k);
    sg = SEG_TAB[d];
    if (LZB && k >= 1 && (sh >> (4*k)) == 16'h0) begin
      an = 4'hF;
      sg = 7'h7F;
    end
  endtask

  task automatic push(input logic clr, input logic ld, input logic [15:0] nib,
                      input logic [6:0] sg, input logic [3:0] an, input logic fd);
    vec_t v;
    v.clr = clr; v.ld = ld; v.nib = nib; v.seg = sg; v.an = an; v.fd = fd;
    vecs.push_back(v);
  endtask

  task automatic pushBlank(input logic ld, input logic [15:0] nib);
    push(1'b0, ld, nib, 7'h7F, 4'hF, 1'b0);
  endtask

  task automatic pushLit(input logic [15:0] sh, input int k, input logic ld,
                         input logic [15:0] nib, input logic fd);
    logic [3:0] an;
    logic [6:0] sg;
    expLit(sh, k, an, sg);
    push(1'b0, ld, nib, sg, an, fd);
  endtask

  // One full slot for digit k: guard cycle (optionally loading) then three
  // lit cycles; frame_done accompanies the last lit cycle of digit 3.
  task automatic pushSlot(input logic [15:0] sh, input int k, input logic ld);
    pushBlank(ld, sh);
    for (int c = 0; c < RD - 1; c++) begin
      pushLit(sh, k, 1'b0, 16'h0, (k == ND - 1) && (c == RD - 2));
    end
  endtask

  task automatic pushFrame(input logic [15:0] sh, input logic ld);
    pushSlot(sh, 0, ld);
    for (int k = 1; k < ND; k++) pushSlot(sh, k, 1'b0);
  endtask

  task automatic applyStimulus(input vec_t v);
    clear   = v.clr;
    load    = v.ld;
    nibbles = v.nib;
  endtask

  task automatic checkOutput(input vec_t v, input int n);
    string nm;
    nm = $sformatf("vec%0d {seg,anode,frame_done}", n);
    checkValue(nm, {20'h0, seg, anode, frame_done}, {20'h0, v.seg, v.an, v.fd});
  endtask

  initial begin
    int pulses;
    int last_pulse;
    logic prev_fd;
    logic [3:0] an3;
    logic [6:0] sg3;

    clear   = 1'b1;
    load    = 1'b0;
    nibbles = 16'h0;

    // Reset held two cycles, then release: blank, then "0" on digit 0.
    push(1'b1, 1'b0, 16'h0, 7'h7F, 4'hF, 1'b0);
    push(1'b1, 1'b0, 16'h0, 7'h7F, 4'hF, 1'b0);
    pushSlot(16'h0, 0, 1'b0);

    // clear wins over load: shadow stays zero, outputs blank.
    push(1'b1, 1'b1, 16'h1234, 7'h7F, 4'hF, 1'b0);

    // Scan order and hex coverage, each frame loaded on its guard cycle.
    pushFrame(16'h1234, 1'b1);
    pushFrame(16'hABCF, 1'b1);
    pushFrame(16'hDE89, 1'b1);

    // Mid-scan clear while idx=2, with load asserted at the same edge.
    pushSlot(16'hDE89, 0, 1'b0);
    pushSlot(16'hDE89, 1, 1'b0);
    pushBlank(1'b0, 16'h0);
    pushLit(16'hDE89, 2, 1'b0, 16'h0, 1'b0);
    push(1'b1, 1'b1, 16'hFFFF, 7'h7F, 4'hF, 1'b0);
    pushSlot(16'h0000, 0, 1'b0);

    // Load during digit 1: old value at the load edge, "F" from the next edge.
    pushBlank(1'b0, 16'h0);
    pushLit(16'h0000, 1, 1'b1, 16'h00F0, 1'b0);
    pushLit(16'h00F0, 1, 1'b0, 16'h0, 1'b0);
    pushLit(16'h00F0, 1, 1'b0, 16'h0, 1'b0);
    pushSlot(16'h00F0, 2, 1'b0);
    pushSlot(16'h00F0, 3, 1'b0);

    // Leading-zero patterns (expectations depend on the build option).
    pushFrame(16'h0007, 1'b1);
    pushFrame(16'h0000, 1'b1);
    pushFrame(16'h0100, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clock);
      #1;
      checkOutput(vecs[i], i);
      running = 1'b1;
    end

    // Free run: frame_done every 16 cycles, on digit 3's last lit cycle,
    // and always followed by the guard cycle ahead of digit 0.
    clear      = 1'b0;
    load       = 1'b0;
    nibbles    = 16'h0;
    pulses     = 0;
    last_pulse = -1;
    prev_fd    = 1'b0;
    expLit(16'h0100, 3, an3, sg3);
    for (int c = 1; c <= 49; c++) begin
      @(posedge clock);
      #1;
      if (prev_fd) begin
        checkValue("blank_after_frame_done", {25'h0, seg}, {25'h0, 7'h7F});
        checkValue("anode_off_after_frame_done", {28'h0, anode}, {28'h0, 4'hF});
      end
      if (frame_done) begin
        pulses++;
        if (last_pulse < 0) begin
          checkValue("first_pulse_cycle", c, 16);
        end else begin
          checkValue("pulse_spacing", c - last_pulse, 16);
        end
        checkValue("anode_at_frame_done", {28'h0, anode}, {28'h0, an3});
        last_pulse = c;
      end
      prev_fd = frame_done;
    end
    checkValue("frame_done_pulse_count", pulses, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
